// File: rtl/io_access_ctrl.sv
// rtl/io_access_ctrl.sv - load/store stage sequencer for data memory and external I/O handshakes
module io_access_ctrl #(
    parameter int MEM_DEPTH  = 128,
    parameter int IN_TIMEOUT = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 io_read,
    input  logic                 io_write,
    input  logic [31:0]          address,
    input  logic                 flag_in,
    input  logic                 out_ack,
    output logic                 writeM,
    output logic                 writeIO,
    output logic                 ctrl,
    output logic                 stop,
    output logic                 in_ack,
    output logic                 out_valid,
    output logic                 addr_err,
    output logic                 in_timeout,
    output logic [CNT_WIDTH-1:0] wait_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        MEM_RD,
        IN_WAIT,
        IN_DONE,
        OUT_WAIT
    } state_t;

    localparam logic [31:0]          MEM_LIMIT   = 32'(MEM_DEPTH);
    localparam logic [CNT_WIDTH-1:0] TO_LAST     = CNT_WIDTH'(IN_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam bit                   TIMEOUT_ON  = (IN_TIMEOUT != 0);

    state_t state, next_state;
    logic   in_consumed;
    logic   addr_ok;
    logic   set_addr_err;
    logic   set_timeout;
    logic   clr_cnt;
    logic   inc_cnt;

    assign addr_ok = (address < MEM_LIMIT);

    // Outputs are forced low while reset is held so an abandoned access cannot pulse a write enable.
    always_comb begin
        next_state   = state;
        writeM       = 1'b0;
        writeIO      = 1'b0;
        ctrl         = 1'b0;
        stop         = 1'b0;
        in_ack       = 1'b0;
        set_addr_err = 1'b0;
        set_timeout  = 1'b0;
        clr_cnt      = 1'b0;
        inc_cnt      = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (io_read) begin
                        stop       = 1'b1;
                        clr_cnt    = 1'b1;
                        next_state = IN_WAIT;
                    end else if (io_write) begin
                        if (!out_valid || out_ack) begin
                            writeIO = 1'b1;
                        end else begin
                            stop       = 1'b1;
                            next_state = OUT_WAIT;
                        end
                    end else if (mem_write) begin
                        if (addr_ok) writeM = 1'b1;
                        else         set_addr_err = 1'b1;
                    end else if (mem_read) begin
                        stop         = 1'b1;
                        set_addr_err = !addr_ok;
                        next_state   = MEM_RD;
                    end
                end
                MEM_RD: begin
                    next_state = IDLE;
                end
                IN_WAIT: begin
                    stop    = 1'b1;
                    inc_cnt = 1'b1;
                    if (flag_in && !in_consumed) begin
                        in_ack     = 1'b1;
                        next_state = IN_DONE;
                    end else if (TIMEOUT_ON && (wait_cnt == TO_LAST)) begin
                        set_timeout = 1'b1;
                        next_state  = IN_DONE;
                    end
                end
                IN_DONE: begin
                    ctrl       = 1'b1;
                    next_state = IDLE;
                end
                OUT_WAIT: begin
                    if (out_ack) begin
                        writeIO    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        stop = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            in_consumed <= 1'b0;
            out_valid   <= 1'b0;
            addr_err    <= 1'b0;
            in_timeout  <= 1'b0;
        end else begin
            if (clr_cnt) begin
                wait_cnt <= '0;
            end else if (inc_cnt && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // A held flag_in may satisfy only one io_read; it must drop before it counts again.
            if (!flag_in) begin
                in_consumed <= 1'b0;
            end else if (in_ack) begin
                in_consumed <= 1'b1;
            end

            if (writeIO) begin
                out_valid <= 1'b1;
            end else if (out_ack) begin
                out_valid <= 1'b0;
            end

            if (set_addr_err) addr_err   <= 1'b1;
            if (set_timeout)  in_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_access_ctrl.sv
// tb/tb_io_access_ctrl.sv - directed self-checking bench for io_access_ctrl
module tb_io_access_ctrl;

    localparam int CW = 16;

    logic          clock;
    logic          reset;
    logic          mem_read;
    logic          mem_write;
    logic          io_read;
    logic          io_write;
    logic [31:0]   address;
    logic          flag_in;
    logic          out_ack;
    logic          writeM;
    logic          writeIO;
    logic          ctrl;
    logic          stop;
    logic          in_ack;
    logic          out_valid;
    logic          addr_err;
    logic          in_timeout;
    logic [CW-1:0] wait_cnt;

    int n_pass  = 0;
    int n_total = 0;

    io_access_ctrl #(
        .MEM_DEPTH (128),
        .IN_TIMEOUT(8),
        .CNT_WIDTH (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .io_read   (io_read),
        .io_write  (io_write),
        .address   (address),
        .flag_in   (flag_in),
        .out_ack   (out_ack),
        .writeM    (writeM),
        .writeIO   (writeIO),
        .ctrl      (ctrl),
        .stop      (stop),
        .in_ack    (in_ack),
        .out_valid (out_valid),
        .addr_err  (addr_err),
        .in_timeout(in_timeout),
        .wait_cnt  (wait_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b1; mem_read = 0; mem_write = 0; io_read = 0; io_write = 0;
        address = '0; flag_in = 0; out_ack = 0;
        #1;
        check("rst_stop", 32'(stop), 0);
        check("rst_wait_cnt", 32'(wait_cnt), 0);
        check("rst_flags", {28'd0, out_valid, addr_err, in_timeout, writeM}, 0);
        tick();
        reset = 1'b0;

        // reset pulse in the middle of an input wait
        io_read = 1; #1;
        check("rd_idle_stop", 32'(stop), 1);
        tick(); tick(); tick();
        check("mid_wait_cnt", 32'(wait_cnt), 2);
        reset = 1'b1; #1;
        check("midrst_stop", 32'(stop), 0);
        check("midrst_cnt", 32'(wait_cnt), 0);
        check("midrst_ctrl", 32'(ctrl), 0);
        io_read = 0;
        tick();
        reset = 1'b0;

        // in-range store
        mem_write = 1; address = 5; #1;
        check("st_writeM", 32'(writeM), 1);
        check("st_stop", 32'(stop), 0);
        tick();
        mem_write = 0;
        check("st_addr_err", 32'(addr_err), 0);

        // load: one stall cycle
        mem_read = 1; address = 10; #1;
        check("ld_stop1", 32'(stop), 1);
        check("ld_ctrl1", 32'(ctrl), 0);
        tick(); #1;
        check("ld_stop2", 32'(stop), 0);
        check("ld_ctrl2", 32'(ctrl), 0);
        tick();
        mem_read = 0; #1;
        check("ld_idle_stop", 32'(stop), 0);
        check("ld_addr_err", 32'(addr_err), 0);

        // out-of-range store
        mem_write = 1; address = 200; #1;
        check("oor_writeM", 32'(writeM), 0);
        check("oor_stop", 32'(stop), 0);
        tick();
        mem_write = 0;
        check("oor_addr_err", 32'(addr_err), 1);
        tick();
        check("oor_sticky", 32'(addr_err), 1);

        // input handshake after 4 wait cycles
        flag_in = 0; io_read = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("inw_stop", 32'(stop), 1);
            check("inw_ack", 32'(in_ack), 0);
            tick();
        end
        check("inw_cnt4", 32'(wait_cnt), 4);
        flag_in = 1; #1;
        check("inw_ack_pulse", 32'(in_ack), 1);
        check("inw_stop_ack", 32'(stop), 1);
        tick(); #1;
        check("indone_ctrl", 32'(ctrl), 1);
        check("indone_stop", 32'(stop), 0);
        check("indone_ack", 32'(in_ack), 0);
        tick();
        io_read = 0; #1;
        check("in_after_ctrl", 32'(ctrl), 0);

        // held flag_in must not satisfy two back-to-back reads
        flag_in = 0;
        tick();
        flag_in = 1; io_read = 1;
        tick(); #1;
        check("held1_ack", 32'(in_ack), 1);
        tick(); #1;
        check("held1_ctrl", 32'(ctrl), 1);
        tick(); #1;
        check("held2_idle_stop", 32'(stop), 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            check("held2_no_ack", 32'(in_ack), 0);
            check("held2_stop", 32'(stop), 1);
            tick();
        end
        flag_in = 0; #1;
        check("held2_low_ack", 32'(in_ack), 0);
        tick();
        flag_in = 1; #1;
        check("held2_ack", 32'(in_ack), 1);
        tick(); #1;
        check("held2_ctrl", 32'(ctrl), 1);
        check("held2_to", 32'(in_timeout), 0);
        tick();
        io_read = 0; flag_in = 0;

        // timeout after 8 cycles in the wait state
        io_read = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            check("to_stop", 32'(stop), 1);
            check("to_no_ack", 32'(in_ack), 0);
            check("to_not_yet", 32'(in_timeout), 0);
            tick();
        end
        #1;
        check("to_flag", 32'(in_timeout), 1);
        check("to_ctrl", 32'(ctrl), 1);
        check("to_stop_done", 32'(stop), 0);
        check("to_ack", 32'(in_ack), 0);
        check("to_cnt", 32'(wait_cnt), 8);
        tick();
        io_read = 0; #1;
        check("to_ctrl_off", 32'(ctrl), 0);
        check("to_sticky", 32'(in_timeout), 1);

        // output backpressure, with io_write outranking mem_write
        io_write = 1; mem_write = 1; address = 5; out_ack = 0; #1;
        check("ow1_writeIO", 32'(writeIO), 1);
        check("ow1_writeM", 32'(writeM), 0);
        check("ow1_stop", 32'(stop), 0);
        tick();
        mem_write = 0;
        check("ow1_valid", 32'(out_valid), 1);
        #1;
        check("ow2_writeIO", 32'(writeIO), 0);
        check("ow2_stop", 32'(stop), 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ow_wait_stop", 32'(stop), 1);
            check("ow_wait_wio", 32'(writeIO), 0);
            tick();
        end
        out_ack = 1; #1;
        check("ow_ack_wio", 32'(writeIO), 1);
        check("ow_ack_stop", 32'(stop), 0);
        tick();
        io_write = 0; out_ack = 0; #1;
        check("ow_valid_kept", 32'(out_valid), 1);
        check("ow_idle_stop", 32'(stop), 0);
        out_ack = 1;
        tick();
        out_ack = 0;
        check("ow_valid_clr", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/io_access_ctrl.md
Name: io_access_ctrl

Overview:
- Sequences data-memory and I/O accesses for the load/store stage of the processor.
- Decodes access requests from the control unit and drives the data memory/IO unit's write enables (writeM, writeIO) and read-mux select (ctrl).
- Generates the pipeline stall (stop).
- Runs a valid/ack handshake with the external input and output devices, with address range checking and an input-wait timeout.

Parameters:
MEM_DEPTH, 128, number of data-memory words; valid addresses are 0..MEM_DEPTH-1
IN_TIMEOUT, 0, maximum cycles spent in IN_WAIT before abort; 0 disables the timeout
CNT_WIDTH, 16, width of the wait counter

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
mem_read  in  1  load request from control unit (level, held while stop=1)
mem_write  in  1  store request
io_read  in  1  input-instruction request
io_write  in  1  output-instruction request
address  in  32  word address for memory accesses
flag_in  in  1  external input data valid (level)
out_ack  in  1  external output device accepted out data
writeM  out  1  data-memory write enable
writeIO  out  1  output-register load enable
ctrl  out  1  read-mux select: 1 = IO input data, 0 = memory data
stop  out  1  stall to the processor
in_ack  out  1  one-cycle pulse: input word captured
out_valid  out  1  output register holds data not yet acknowledged
addr_err  out  1  sticky: out-of-range memory access seen
in_timeout  out  1  sticky: input wait aborted
wait_cnt  out  CNT_WIDTH  cycles spent in current IN_WAIT

Behaviour:
- Reset (async):
  - State returns to IDLE.
  - All outputs are 0, wait_cnt = 0, in_consumed = 0.
  - Reset asserted mid-operation abandons the access; no write enable pulses afterwards.
- Request priority when several are high in IDLE: io_read > io_write > mem_write > mem_read. Lower-priority requests wait; the control unit holds them because stop=1.
- States: IDLE, MEM_RD, IN_WAIT, IN_DONE, OUT_WAIT.
- mem_write in IDLE:
  - If address < MEM_DEPTH: writeM = 1 combinationally this cycle, no stall, stay IDLE.
  - Otherwise: writeM = 0, addr_err set next edge, no stall.
- mem_read in IDLE (synchronous memory, 1-cycle latency):
  - stop = 1 and ctrl = 0; next state MEM_RD.
  - MEM_RD: stop = 0, ctrl = 0, then IDLE. Total stall is 1 cycle.
  - An out-of-range read also sets addr_err; the timing is unchanged.
- io_read in IDLE: stop = 1; next state IN_WAIT; wait_cnt cleared.
- IN_WAIT:
  - stop = 1 and wait_cnt increments each cycle, saturating at its maximum.
  - If flag_in = 1 and in_consumed = 0: in_ack = 1 this cycle, in_consumed set, next state IN_DONE.
  - Else if IN_TIMEOUT != 0 and wait_cnt == IN_TIMEOUT-1: in_timeout set, next state IN_DONE, no in_ack.
- IN_DONE: stop = 0, ctrl = 1 for exactly one cycle, then IDLE.
- in_consumed: cleared on any edge where flag_in = 0. This prevents one held flag_in from satisfying two consecutive io_reads.
- io_write in IDLE:
  - If out_valid = 0, or out_ack = 1 this cycle: writeIO = 1 combinationally, no stall, out_valid = 1 next edge.
  - Otherwise: stop = 1, next state OUT_WAIT.
- OUT_WAIT:
  - stop = 1 until out_ack = 1.
  - In the out_ack cycle: writeIO = 1, stop = 0, out_valid stays 1, return IDLE.
- out_valid is cleared on an out_ack edge unless writeIO is asserted in the same cycle.
- ctrl default outside IN_DONE is 0.
- writeM and writeIO are never both 1.
- Sticky flags (addr_err, in_timeout) clear only on reset.

Test Plan:
- Reset/store: reset pulse mid-IN_WAIT -> all outputs 0, state IDLE. Then mem_write, address=5 -> writeM=1 same cycle, stop=0, addr_err=0.
- Load and range error: mem_read, address=10 -> stop=1 one cycle, then stop=0, ctrl=0. mem_write, address=200 -> writeM=0, addr_err=1 next edge and stays 1.
- Input handshake: io_read with flag_in=0 for 4 cycles -> stop=1, wait_cnt reaches 4. Then flag_in=1 -> in_ack pulses once, next cycle ctrl=1, stop=0.
- Held input not reused: flag_in held 1 across two back-to-back io_reads -> first completes in 2 cycles. Second stalls with no in_ack until flag_in goes 0 then 1.
- Timeout: IN_TIMEOUT=8, io_read with flag_in=0 -> after 8 stall cycles in_timeout=1, ctrl=1 for one cycle, no in_ack.
- Output backpressure: io_write twice with out_ack=0 -> first writeIO=1 no stall. Second stop=1 until out_ack=1, then writeIO=1 in that cycle and out_valid stays 1.
